// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide engine with HI/LO result registers; one operation in flight.
// Define MDU_UNSIGNED_EN to add an is_unsigned input that selects multu/divu semantics.
module mul_div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
`ifdef MDU_UNSIGNED_EN
  input  logic              is_unsigned,
`endif
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FINISH
  } state_t;

  state_t state, state_next;

  logic              unsigned_op;
  logic              accept_mult, accept_div, accept_zero;
  logic              step_mult, step_div, finish;
  logic [CNT_W-1:0]  iter_cnt;
  logic [PROD_W-1:0] acc;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] opnd;
  logic              sign_p, sign_r;
  logic              is_div, zero_div;

`ifdef MDU_UNSIGNED_EN
  assign unsigned_op = is_unsigned;
`else
  assign unsigned_op = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic             take_abs);
    return (take_abs && v[DATA_W-1]) ? -v : v;
  endfunction

  logic [DATA_W-1:0] mag_a, mag_b;
  assign mag_a = magnitude(operand_a, !unsigned_op);
  assign mag_b = magnitude(operand_b, !unsigned_op);

  // Shift-add step: acc[PROD_W-1:DATA_W] is the partial product, the low half holds the multiplier.
  logic [DATA_W:0] mult_sum;
  assign mult_sum = {1'b0, acc[PROD_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);

  // Restoring step: the low half of acc shifts the dividend out and the quotient in.
  logic [DATA_W:0] div_shift, div_trial;
  assign div_shift = {rem, acc[DATA_W-1]};
  assign div_trial = div_shift - {1'b0, opnd};

  logic [PROD_W-1:0] prod_fix;
  logic [DATA_W-1:0] quo_fix, rem_fix;
  assign prod_fix = sign_p ? -acc : acc;
  assign quo_fix  = sign_p ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem_fix  = sign_r ? -rem : rem;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept_mult = 1'b0;
    accept_div  = 1'b0;
    accept_zero = 1'b0;
    step_mult   = 1'b0;
    step_div    = 1'b0;
    finish      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_mult) begin
          accept_mult = 1'b1;
          state_next  = S_MULT;
        end else if (start_div) begin
          if (operand_b == '0) begin
            accept_zero = 1'b1;
            state_next  = S_FINISH;
          end else begin
            accept_div = 1'b1;
            state_next = S_DIV;
          end
        end
      end
      S_MULT: begin
        step_mult = 1'b1;
        if (iter_cnt == LAST_ITER) state_next = S_FINISH;
      end
      S_DIV: begin
        step_div = 1'b1;
        if (iter_cnt == LAST_ITER) state_next = S_FINISH;
      end
      S_FINISH: begin
        finish     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      rem      <= '0;
      opnd     <= '0;
      iter_cnt <= '0;
      sign_p   <= 1'b0;
      sign_r   <= 1'b0;
      is_div   <= 1'b0;
      zero_div <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;

      if (accept_mult || accept_div) begin
        busy     <= 1'b1;
        is_div   <= accept_div;
        zero_div <= 1'b0;
        iter_cnt <= '0;
        rem      <= '0;
        sign_p   <= !unsigned_op && (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
        sign_r   <= !unsigned_op && operand_a[DATA_W-1];
        opnd     <= accept_mult ? mag_a : mag_b;
        acc      <= {DATA_W'(0), (accept_mult ? mag_b : mag_a)};
      end

      if (accept_zero) begin
        is_div   <= 1'b1;
        zero_div <= 1'b1;
      end

      if (step_mult) begin
        acc      <= {mult_sum, acc[DATA_W-1:1]};
        iter_cnt <= iter_cnt + CNT_W'(1);
      end

      if (step_div) begin
        if (div_trial[DATA_W]) begin
          rem               <= div_shift[DATA_W-1:0];
          acc[DATA_W-1:0]   <= {acc[DATA_W-2:0], 1'b0};
        end else begin
          rem               <= div_trial[DATA_W-1:0];
          acc[DATA_W-1:0]   <= {acc[DATA_W-2:0], 1'b1};
        end
        iter_cnt <= iter_cnt + CNT_W'(1);
      end

      // Results land in one edge so hi/lo never show a partial update
      if (finish) begin
        busy     <= 1'b0;
        done     <= 1'b1;
        div_zero <= zero_div;
        if (!zero_div) begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[PROD_W-1:DATA_W];
            lo <= prod_fix[DATA_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: cycle-level arithmetic model plus literal result table.
module tb_mul_div_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_OPS  = 12;
  localparam int          LATENCY = 33;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start_mult = 1'b0;
  logic              start_div = 1'b0;
  logic [DATA_W-1:0] operand_a = '0;
  logic [DATA_W-1:0] operand_b = '0;
`ifdef MDU_UNSIGNED_EN
  logic              is_unsigned = 1'b0;
`endif
  logic              busy, done, div_zero;
  logic [DATA_W-1:0] hi, lo;

  mul_div_unit #(.DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
`ifdef MDU_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clock = ~clock;

  // Expected hi/lo/div_zero for each done pulse, in issue order
  logic [31:0] lit_hi [N_OPS] = '{32'hFFFFFFFF, 32'h3FFFFFFF, 32'h00000000, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000,
                                  32'hFFFFFFFE, 32'h00000002, 32'h00000000, 32'h40000000};
  logic [31:0] lit_lo [N_OPS] = '{32'hFFFFFFEB, 32'h00000001, 32'h01234500, 32'hFFFFFFFD,
                                  32'hFFFFFFFD, 32'h80000000, 32'h00000018, 32'h0000000F,
                                  32'hFFFFFFF2, 32'hFFFFFFF2, 32'h00000001, 32'h00000000};
  logic        lit_dz [N_OPS] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Behavioural model: plain 64-bit arithmetic plus a countdown to the result edge
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  longint      sa, sb, q, r;
  logic [63:0] prod;

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
          m_dz   = p_dz;
          if (!p_dz) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (start_mult || start_div) begin
        sa = longint'($signed(operand_a));
        sb = longint'($signed(operand_b));
        if (start_mult) begin
          prod = 64'(sa * sb);
          p_hi = prod[63:32];
          p_lo = prod[31:0];
          p_dz = 1'b0; m_busy = 1'b1; m_left = LATENCY;
        end else if (operand_b == 0) begin
          p_dz = 1'b1; m_left = 1;
        end else begin
          q = sa / sb;
          r = sa % sb;
          p_lo = 32'(q);
          p_hi = 32'(r);
          p_dz = 1'b0; m_busy = 1'b1; m_left = LATENCY;
        end
      end
    end
  end

  int tests = 0, fails = 0, done_idx = 0;
  bit chk_en = 1'b0, end_chk = 1'b0, end_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("div_zero", 32'(div_zero), 32'(m_dz));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      if (done === 1'b1) begin
        if (done_idx < N_OPS) begin
          check("lit_hi", hi, lit_hi[done_idx]);
          check("lit_lo", lo, lit_lo[done_idx]);
          check("lit_dz", 32'(div_zero), 32'(lit_dz[done_idx]));
        end else begin
          check("done_index", 32'(done_idx), 32'(N_OPS - 1));
        end
        done_idx++;
      end
      if (end_chk && !end_seen) begin
        end_seen = 1'b1;
        check("done_total", 32'(done_idx), 32'(N_OPS));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    start_mult = m;
    start_div  = d;
    operand_a  = a;
    operand_b  = b;
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  initial begin
    idle(2);
    chk_en = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);

    issue(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    idle(35);

    // Second op issued on the cycle done is high
    issue(1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    idle(33);
    issue(1'b1, 1'b0, 32'h00012345, 32'h00000100);
    idle(35);

    issue(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    idle(35);
    issue(1'b0, 1'b1, 32'd5, 32'd0);
    idle(3);
    issue(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    idle(35);

    // Simultaneous starts, then a divide pulse that must be ignored at E5
    issue(1'b1, 1'b1, 32'd6, 32'd4);
    idle(4);
    issue(1'b0, 1'b1, 32'd9, 32'd3);
    idle(30);

    // Reset lands on E10 of a divide
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    idle(9);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);

    issue(1'b1, 1'b0, 32'd3, 32'd5);
    idle(35);
    issue(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7);
    idle(35);
    issue(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9);
    idle(35);
    issue(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(35);
    issue(1'b1, 1'b0, 32'h80000000, 32'h80000000);
    idle(35);

    end_chk = 1'b1;
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
